// File: rtl/ascon_pack.sv
// Shared ASCON types and constants: 320-bit state, inverse-diffusion rotation table and FSM encoding.
package ascon_pack;

  typedef logic [4:0][63:0] type_state;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } inv_fsm_t;

  // Base right-rotation pair (a, b) of the forward diffusion, one pair per row.
  localparam logic [5:0] ROT_AMOUNT [5][2] = '{
    '{6'd19, 6'd28},
    '{6'd61, 6'd39},
    '{6'd1,  6'd6},
    '{6'd10, 6'd17},
    '{6'd7,  6'd41}
  };

  // A shift by 64 yields zero, so an amount of 0 returns x unchanged.
  function automatic logic [63:0] rotr(input logic [63:0] x, input logic [5:0] n);
    return (x >> n) | (x << (7'd64 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/inv_diffusion_row.sv
// One factor (1 + X^(a*2^k) + X^(b*2^k)) of the inverse diffusion applied to a single 64-bit lane.
module inv_diffusion_row
  import ascon_pack::*;
(
  input  logic [63:0] lane,
  input  logic [2:0]  round,
  input  logic [5:0]  rot_a,
  input  logic [5:0]  rot_b,
  output logic [63:0] result
);

  logic [5:0] amt_a;
  logic [5:0] amt_b;

  // Multiplying the amount by 2^k modulo the lane width is a truncated left shift.
  assign amt_a  = rot_a << round;
  assign amt_b  = rot_b << round;
  assign result = lane ^ rotr(lane, amt_a) ^ rotr(lane, amt_b);

endmodule

// File: rtl/inv_diffusion.sv
// Iterative inverse of the ASCON linear layer: one product factor per clock, six rounds per state.
module inv_diffusion
  import ascon_pack::*;
#(
  parameter int NB_ROUNDS = 6
) (
  input  logic      clock_i,
  input  logic      resetb_i,
  input  logic      start_i,
  input  type_state state_i,
  output type_state state_o,
  output logic      busy_o,
  output logic      done_o
);

  localparam logic [2:0] LAST_ROUND = 3'(NB_ROUNDS - 1);

  inv_fsm_t  fsm_q, fsm_d;
  logic [2:0] round_q, round_d;
  type_state  work_q, work_d;
  type_state  round_out;

  for (genvar r = 0; r < 5; r++) begin : g_row
    inv_diffusion_row u_row (
      .lane   (work_q[r]),
      .round  (round_q),
      .rot_a  (ROT_AMOUNT[r][0]),
      .rot_b  (ROT_AMOUNT[r][1]),
      .result (round_out[r])
    );
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      round_q <= 3'd0;
      work_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      work_q  <= work_d;
    end
  end

  // Handshake: start_i is accepted only on an edge where the FSM is IDLE;
  // done_o marks the single DONE cycle and state_o then holds until the next accept.
  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    work_d  = work_q;
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          work_d  = state_i;
          round_d = 3'd0;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        work_d  = round_out;
        round_d = round_q + 3'd1;
        if (round_q == LAST_ROUND) fsm_d = DONE;
      end
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  assign state_o = work_q;
  assign busy_o  = (fsm_q != IDLE);
  assign done_o  = (fsm_q == DONE);

endmodule

// File: tb/tb_inv_diffusion.sv
// Bench for inv_diffusion: random and directed states against a polynomial-inverse reference.
module tb_inv_diffusion;
  import ascon_pack::*;

  logic      clock_i = 1'b0;
  logic      resetb_i;
  logic      start_i;
  type_state state_i;
  type_state state_o;
  logic      busy_o;
  logic      done_o;

  always #5 clock_i = ~clock_i;

  inv_diffusion dut (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .start_i  (start_i),
    .state_i  (state_i),
    .state_o  (state_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [319:0] exp_q[$];
  int           acc_q[$];
  int           cyc       = 0;
  int           busy_from = -1;
  int           busy_to   = -2;
  logic         prev_done = 1'b0;

  int unsigned base_a [5] = '{19, 61, 1, 10, 7};
  int unsigned base_b [5] = '{28, 39, 6, 17, 41};
  logic [63:0] inv_poly [5];

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_rotr(input logic [63:0] x, input int n);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = x[(i + n) % 64];
    return r;
  endfunction

  function automatic type_state diffusion(input type_state s);
    type_state r;
    for (int k = 0; k < 5; k++)
      r[k] = s[k] ^ ref_rotr(s[k], base_a[k]) ^ ref_rotr(s[k], base_b[k]);
    return r;
  endfunction

  // Product in GF(2)[X]/(X^64+1); bit i is the coefficient of X^i.
  function automatic logic [63:0] poly_mul(input logic [63:0] p, input logic [63:0] q);
    logic [63:0] r = '0;
    for (int i = 0; i < 64; i++)
      if (p[i])
        for (int j = 0; j < 64; j++)
          if (q[j]) r[(i + j) % 64] ^= 1'b1;
    return r;
  endfunction

  task automatic build_inverse();
    logic [63:0] p;
    logic [63:0] acc;
    for (int k = 0; k < 5; k++) begin
      p = '0;
      p[0] = 1'b1;
      p[base_a[k]] ^= 1'b1;
      p[base_b[k]] ^= 1'b1;
      acc = p;
      for (int e = 1; e < 63; e++) acc = poly_mul(acc, p);
      inv_poly[k] = acc;
    end
  endtask

  function automatic type_state inverse_model(input type_state s);
    type_state r = '0;
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 64; i++)
        if (inv_poly[k][i]) r[k] ^= ref_rotr(s[k], i);
    return r;
  endfunction

  // ---------------- acceptance tracker and monitor ----------------
  always @(negedge clock_i) begin
    cyc++;
    if (!resetb_i) begin
      exp_q.delete();
      acc_q.delete();
      busy_from = -1;
      busy_to   = -2;
      prev_done = 1'b0;
    end else begin
      check("busy", 320'(busy_o), 320'(cyc >= busy_from && cyc <= busy_to));
      check("done_pulse_width", 320'(done_o & prev_done), 320'd0);
      if (done_o) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 320'(done_o), 320'd0);
        end else begin
          check("result", state_o, exp_q.pop_front());
          check("latency", 320'(cyc - acc_q.pop_front()), 320'd7);
        end
      end
      prev_done = done_o;
      if (start_i && !busy_o) begin
        exp_q.push_back(inverse_model(state_i));
        acc_q.push_back(cyc);
        busy_from = cyc + 1;
        busy_to   = cyc + 7;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  function automatic type_state rand_state();
    type_state s;
    for (int k = 0; k < 5; k++) s[k] = {$urandom(), $urandom()};
    return s;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy_o; i++) step();
    check("idle_timeout", 320'(busy_o), 320'd0);
  endtask

  task automatic issue(input type_state s);
    start_i = 1'b1;
    state_i = s;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done_o) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) check("done_timeout", 320'(done_o), 320'd1);
  endtask

  task automatic run_directed(input string name, input type_state s, input type_state exp);
    bit ok;
    wait_idle();
    issue(s);
    wait_done(ok);
    if (ok) begin
      check(name, state_o, exp);
      step();
      step();
      check({name, "_hold"}, state_o, exp);
    end
  endtask

  initial begin
    type_state x, a, b, ones, zeros, row2;
    bit ok;

    build_inverse();
    resetb_i = 1'b0;
    start_i  = 1'b0;
    state_i  = '0;
    repeat (3) step();
    check("reset_state", state_o, '0);
    check("reset_busy", 320'(busy_o), 320'd0);
    check("reset_done", 320'(done_o), 320'd0);
    resetb_i = 1'b1;
    step();

    row2 = '0;
    row2[2] = 64'h8400000000000001;
    x = '0;
    x[2] = 64'h0000000000000001;
    run_directed("row2_single_bit", row2, x);

    x[0] = 64'h8859263f4c5d6e8f;
    x[1] = 64'h00c18e8584858607;
    x[2] = 64'h7f7f7f7f7f7f7f8f;
    x[3] = 64'h7f7f7f7f7f7f7f8f;
    x[4] = 64'h8888888a88888888;
    run_directed("roundtrip_inv", diffusion(x), x);

    wait_idle();
    issue(x);
    wait_done(ok);
    if (ok) check("roundtrip_fwd", diffusion(state_o), x);

    ones  = '1;
    zeros = '0;
    run_directed("fixed_ones", ones, ones);
    run_directed("fixed_zeros", zeros, zeros);

    // start pulsed at T3 with a different state must be ignored
    wait_idle();
    a = rand_state();
    b = rand_state();
    issue(a);
    step();
    start_i = 1'b1;
    state_i = b;
    step();
    start_i = 1'b0;
    wait_done(ok);
    if (ok) check("busy_start_ignored", state_o, inverse_model(a));

    // reset at T4 of a running operation
    wait_idle();
    issue(rand_state());
    repeat (4) step();
    resetb_i = 1'b0;
    #1;
    check("midrun_reset_state", state_o, '0);
    check("midrun_reset_busy", 320'(busy_o), 320'd0);
    check("midrun_reset_done", 320'(done_o), 320'd0);
    repeat (2) step();
    resetb_i = 1'b1;
    step();
    a = rand_state();
    run_directed("after_reset", a, inverse_model(a));

    for (int t = 0; t < 8; t++) begin
      wait_idle();
      issue(rand_state());
      wait_done(ok);
    end

    // start held high: one accept every 8 cycles
    wait_idle();
    start_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      state_i = rand_state();
      step();
    end
    start_i = 1'b0;
    wait_idle();
    repeat (12) step();

    check("scoreboard_drained", 320'(exp_q.size()), 320'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
